// File: rtl/regfile_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter_pkg
// Purpose  : Shared types and constants for the register-file port arbiter:
//            FSM state encoding, client indices, address/data widths.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_port_arbiter_pkg;

  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned BURST_CNT_W = 4;

  localparam logic CLIENT0 = 1'b0;  // core writeback
  localparam logic CLIENT1 = 1'b1;  // debug/load unit

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_LOCK = 3'd4
  } arb_state_t;

  // States in which the port is considered occupied.
  function automatic logic is_busy_state(input arb_state_t s);
    return (s == ST_RD1) || (s == ST_RD2) || (s == ST_LOCK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter_if
// Purpose  : Client request/grant signals and register-file port bundle.
//            slave  = arbiter side, master = clients plus register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_port_arbiter_if;
  import regfile_port_arbiter_pkg::*;

  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_lock;
  logic              c0_gnt;
  logic              c1_gnt;
  logic              c0_rvalid;
  logic              c1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rf_regWrite;
  logic [ADDR_W-1:0] rf_reg1;
  logic [DATA_W-1:0] rf_dadoEscr;
  logic [DATA_W-1:0] rf_dado1;
  logic              busy;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
    input  rf_dado1,
    output c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rdata,
    output rf_regWrite, rf_reg1, rf_dadoEscr, busy
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata, c1_lock,
    output rf_dado1,
    input  c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rdata,
    input  rf_regWrite, rf_reg1, rf_dadoEscr, busy
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-client round-robin arbiter. Grants are combinational from
//            the current requests and the registered priority pointer; the
//            pointer moves to the other client after every grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import regfile_port_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic i_enable,   // grants permitted this cycle
  input  logic i_c1_only,  // burst lock: client 0 is not eligible
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // Client that wins when both request.
  logic r_prio;

  assign o_gnt1 = i_enable && i_req1 && (i_c1_only || !i_req0 || (r_prio == CLIENT1));
  assign o_gnt0 = i_enable && !i_c1_only && i_req0 && !o_gnt1;

  // Hand priority to the client that was not just served. Lock exit needs no
  // extra handling: the last locked grant went to client 1, so client 0 is next.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio <= CLIENT0;
    end else if (o_gnt0) begin
      r_prio <= CLIENT1;
    end else if (o_gnt1) begin
      r_prio <= CLIENT0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_port_arbiter
// Purpose  : Shares one register-file write/read-1 port between the core
//            writeback (client 0) and the debug/load unit (client 1).
//            Writes take one cycle, reads occupy the port for three cycles,
//            client 1 may lock the port for a bounded burst.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4   // 1..15 grants per lock burst
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_port_arbiter_if.slave bus
);

  localparam logic [BURST_CNT_W-1:0] BURST_LIMIT  = BURST_CNT_W'(MAX_BURST);
  localparam logic                   LOCK_ENABLED = (MAX_BURST > 1);

  arb_state_t              r_state;
  arb_state_t              w_state_next;
  logic [BURST_CNT_W-1:0]  r_burst_cnt;
  logic [BURST_CNT_W-1:0]  w_burst_next;
  logic [BURST_CNT_W-1:0]  w_burst_inc;
  logic                    r_busy;
  logic                    r_rd_client;

  logic                    r_regwrite;
  logic [ADDR_W-1:0]       r_reg1;
  logic [DATA_W-1:0]       r_dado_escr;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_rvalid0;
  logic                    r_rvalid1;

  logic                    w_grant_ok;
  logic                    w_c1_only;
  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_any_gnt;
  logic                    w_sel_we;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [DATA_W-1:0]       w_sel_wdata;

  // No grants under reset or while a read owns rf_reg1.
  assign w_grant_ok = !reset &&
                      ((r_state == ST_IDLE) || (r_state == ST_WR) || (r_state == ST_LOCK));
  // A lock only shuts out client 0 while client 1 keeps asserting it.
  assign w_c1_only  = (r_state == ST_LOCK) && bus.c1_lock;

  rr_arbiter2 u_rr (
    .clock     (clock),
    .reset     (reset),
    .i_enable  (w_grant_ok),
    .i_c1_only (w_c1_only),
    .i_req0    (bus.c0_req),
    .i_req1    (bus.c1_req),
    .o_gnt0    (w_gnt0),
    .o_gnt1    (w_gnt1)
  );

  assign w_any_gnt   = w_gnt0 || w_gnt1;
  assign w_sel_we    = w_gnt1 ? bus.c1_we    : bus.c0_we;
  assign w_sel_addr  = w_gnt1 ? bus.c1_addr  : bus.c0_addr;
  assign w_sel_wdata = w_gnt1 ? bus.c1_wdata : bus.c0_wdata;
  assign w_burst_inc = r_burst_cnt + 4'd1;

  // Burst counter: nonzero exactly while a lock is held; frozen across reads.
  always_comb begin
    w_burst_next = '0;
    if ((r_state == ST_RD1) || (r_state == ST_RD2)) begin
      w_burst_next = r_burst_cnt;
    end else if (w_c1_only) begin
      if (w_gnt1) begin
        w_burst_next = (w_burst_inc >= BURST_LIMIT) ? '0 : w_burst_inc;
      end else begin
        w_burst_next = r_burst_cnt;
      end
    end else if (w_gnt1 && bus.c1_lock && LOCK_ENABLED) begin
      w_burst_next = 4'd1;
    end
  end

  // Next state: reads walk RD1/RD2, an active burst parks in LOCK.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_RD1:  w_state_next = ST_RD2;
      ST_RD2:  w_state_next = (r_burst_cnt != '0) ? ST_LOCK : ST_IDLE;
      default: begin
        if (w_any_gnt && !w_sel_we) begin
          w_state_next = ST_RD1;
        end else if (w_burst_next != '0) begin
          w_state_next = ST_LOCK;
        end else if (w_any_gnt) begin
          w_state_next = ST_WR;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
    endcase
  end

  // FSM state, burst counter, busy flag and owner of the in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
      r_busy      <= 1'b0;
      r_rd_client <= CLIENT0;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_next;
      r_busy      <= is_busy_state(w_state_next);
      if (w_any_gnt && !w_sel_we) begin
        r_rd_client <= w_gnt1;
      end
    end
  end

  // Register-file port drive and read-data return; reset drops a pending read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_regwrite  <= 1'b0;
      r_reg1      <= '0;
      r_dado_escr <= '0;
      r_rdata     <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_regwrite <= w_any_gnt && w_sel_we;
      if (w_any_gnt) begin
        r_reg1 <= w_sel_addr;
        if (w_sel_we) begin
          r_dado_escr <= w_sel_wdata;
        end
      end
      r_rvalid0 <= (r_state == ST_RD2) && (r_rd_client == CLIENT0);
      r_rvalid1 <= (r_state == ST_RD2) && (r_rd_client == CLIENT1);
      if (r_state == ST_RD2) begin
        r_rdata <= bus.rf_dado1;
      end
    end
  end

  assign bus.c0_gnt      = w_gnt0;
  assign bus.c1_gnt      = w_gnt1;
  assign bus.c0_rvalid   = r_rvalid0;
  assign bus.c1_rvalid   = r_rvalid1;
  assign bus.rdata       = r_rdata;
  assign bus.rf_regWrite = r_regwrite;
  assign bus.rf_reg1     = r_reg1;
  assign bus.rf_dadoEscr = r_dado_escr;
  assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Purpose  : Self-checking bench: directed scenarios followed by random
//            traffic, compared cycle by cycle against a transaction-level
//            reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;
  import regfile_port_arbiter_pkg::*;

  localparam int MAX_BURST = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Register file attached to the port (never reset by the arbiter).
  logic [DATA_W-1:0] rf_mem [4] = '{default: '0};
  always @(posedge clock) if (bus.rf_regWrite) rf_mem[bus.rf_reg1] <= bus.rf_dadoEscr;
  assign bus.rf_dado1 = rf_mem[bus.rf_reg1];

  // Client request queues: the front entry is held on the bus until granted.
  txn_t q0[$];
  txn_t q1[$];

  // Reference model: priority owner, cycles the port stays blocked by a read,
  // grants used in the current lock burst, architectural register contents.
  int                m_prio, m_block, m_burst, m_rd_client;
  logic [DATA_W-1:0] m_rd_data;
  logic [DATA_W-1:0] m_regs [4] = '{default: '0};
  logic              e_regwrite, e_rv0, e_rv1, e_busy;
  logic [ADDR_W-1:0] e_reg1;
  logic [DATA_W-1:0] e_wdata, e_rdata;

  logic              obs_g0, obs_g1, obs_regwrite, obs_rv0, obs_rv1, obs_busy;
  logic [ADDR_W-1:0] obs_reg1;
  logic [DATA_W-1:0] obs_wd, obs_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_prio = 0; m_block = 0; m_burst = 0; m_rd_client = 0; m_rd_data = '0;
    e_regwrite = 0; e_rv0 = 0; e_rv1 = 0; e_busy = 0;
    e_reg1 = '0; e_wdata = '0; e_rdata = '0;
  endfunction

  function automatic void drive_inputs();
    txn_t t0, t1;
    t0 = (q0.size() != 0) ? q0[0] : '0;
    t1 = (q1.size() != 0) ? q1[0] : '0;
    bus.c0_req = (q0.size() != 0); bus.c0_we = t0.we; bus.c0_addr = t0.addr; bus.c0_wdata = t0.wdata;
    bus.c1_req = (q1.size() != 0); bus.c1_we = t1.we; bus.c1_addr = t1.addr; bus.c1_wdata = t1.wdata;
  endfunction

  // One clock cycle: present requests, compare every output against the
  // model, advance the model, move to just after the next rising edge.
  task automatic do_cycle();
    int   winner, blk0;
    logic c1_only;
    txn_t t;
    drive_inputs();
    #1;
    obs_g0 = bus.c0_gnt; obs_g1 = bus.c1_gnt; obs_regwrite = bus.rf_regWrite;
    obs_reg1 = bus.rf_reg1; obs_wd = bus.rf_dadoEscr; obs_rv0 = bus.c0_rvalid;
    obs_rv1 = bus.c1_rvalid; obs_rdata = bus.rdata; obs_busy = bus.busy;

    winner  = -1;
    c1_only = (m_burst != 0) && bus.c1_lock;
    if (!reset && m_block == 0) begin
      if (c1_only) begin
        if (bus.c1_req) winner = 1;
      end else if (bus.c0_req && bus.c1_req) winner = m_prio;
      else if (bus.c0_req) winner = 0;
      else if (bus.c1_req) winner = 1;
    end

    check("gnt_onehot",  32'(obs_g0 & obs_g1), 32'(0));
    check("c0_gnt",      32'(obs_g0),       32'(winner == 0));
    check("c1_gnt",      32'(obs_g1),       32'(winner == 1));
    check("rf_regWrite", 32'(obs_regwrite), 32'(e_regwrite));
    check("rf_reg1",     32'(obs_reg1),     32'(e_reg1));
    check("rf_dadoEscr", 32'(obs_wd),       32'(e_wdata));
    check("c0_rvalid",   32'(obs_rv0),      32'(e_rv0));
    check("c1_rvalid",   32'(obs_rv1),      32'(e_rv1));
    check("rdata",       32'(obs_rdata),    32'(e_rdata));
    check("busy",        32'(obs_busy),     32'(e_busy));

    if (reset) begin
      model_reset();
    end else begin
      blk0 = m_block;
      e_regwrite = 0; e_rv0 = 0; e_rv1 = 0;
      if (m_block > 0) begin
        m_block--;
        if (m_block == 0) begin
          if (m_rd_client == 0) e_rv0 = 1; else e_rv1 = 1;
          e_rdata = m_rd_data;
        end
      end
      if (winner >= 0) begin
        t = (winner == 0) ? q0[0] : q1[0];
        e_reg1 = t.addr;
        if (t.we) begin
          e_regwrite = 1; e_wdata = t.wdata; m_regs[t.addr] = t.wdata;
        end else begin
          m_block = 2; m_rd_client = winner; m_rd_data = m_regs[t.addr];
        end
        m_prio = 1 - winner;
        if (winner == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (blk0 == 0) begin
        if (c1_only) begin
          if (winner == 1) begin
            m_burst++;
            if (m_burst >= MAX_BURST) m_burst = 0;
          end
        end else begin
          m_burst = (winner == 1 && bus.c1_lock && MAX_BURST > 1) ? 1 : 0;
        end
      end
      e_busy = (m_block > 0) || (m_burst > 0);
    end
    @(posedge clock);
    #1;
  endtask

  function automatic txn_t mk(input logic we, input int addr, input int data);
    txn_t t;
    t.we = we; t.addr = ADDR_W'(addr); t.wdata = DATA_W'(data);
    return t;
  endfunction

  function automatic int obs_winner();
    return obs_g1 ? 1 : (obs_g0 ? 0 : -1);
  endfunction

  initial begin
    int seq[$];
    int exp_lock [6] = '{1, 1, 1, 1, 0, 1};
    int exp_rr   [4] = '{0, 1, 0, 1};
    int guard;

    bus.c1_lock = 1'b0;
    drive_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    do_cycle();                       // outputs while held in reset
    reset = 1'b0;
    do_cycle();

    // Single write: grant, one-cycle write strobe, strobe off.
    q0.push_back(mk(1'b1, 2, 8'hA5));
    do_cycle(); check("wr_gnt", 32'(obs_g0), 32'(1));
    do_cycle(); check("wr_strobe", 32'(obs_regwrite), 32'(1));
    check("wr_addr", 32'(obs_reg1), 32'(2));
    check("wr_data", 32'(obs_wd), 32'(8'hA5));
    do_cycle(); check("wr_strobe_off", 32'(obs_regwrite), 32'(0));

    // Read back: port blocked for two cycles even with client 1 waiting.
    q0.push_back(mk(1'b0, 2, 0));
    do_cycle(); check("rd_gnt", 32'(obs_g0), 32'(1));
    q1.push_back(mk(1'b1, 0, 8'h3C));
    do_cycle(); check("rd_block1", 32'(obs_g1), 32'(0));
    do_cycle(); check("rd_block2", 32'(obs_g1), 32'(0));
    do_cycle(); check("rd_rvalid", 32'(obs_rv0), 32'(1));
    check("rd_data", 32'(obs_rdata), 32'(8'hA5));
    check("rd_then_c1", 32'(obs_g1), 32'(1));

    // Both clients streaming writes alternate.
    q0.push_back(mk(1'b1, 0, 8'h11)); q0.push_back(mk(1'b1, 1, 8'h22));
    q1.push_back(mk(1'b1, 3, 8'h33)); q1.push_back(mk(1'b1, 0, 8'h44));
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check("rr_order", 32'(obs_winner()), 32'(exp_rr[i]));
    end

    // Lock burst: move priority to client 1, then lock with six writes queued.
    q0.push_back(mk(1'b1, 1, 8'h55));
    do_cycle();
    bus.c1_lock = 1'b1;
    for (int i = 0; i < 6; i++) q1.push_back(mk(1'b1, 3, 8'h60 + i));
    q0.push_back(mk(1'b1, 1, 8'h70)); q0.push_back(mk(1'b1, 1, 8'h71));
    seq.delete();
    guard = 0;
    while (seq.size() < 6 && guard < 20) begin
      do_cycle();
      if (obs_winner() >= 0) seq.push_back(obs_winner());
      guard++;
    end
    check("lock_grants_seen", 32'(seq.size()), 32'(6));
    for (int i = 0; i < 6 && i < seq.size(); i++) check("lock_order", 32'(seq[i]), 32'(exp_lock[i]));
    bus.c1_lock = 1'b0;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 20) begin
      do_cycle();
      guard++;
    end
    check("lock_drain", 32'(q0.size() + q1.size()), 32'(0));
    do_cycle();

    // Reset during RD1 discards the read; a later read completes.
    q0.push_back(mk(1'b0, 2, 0));
    do_cycle(); check("rst_rd_gnt", 32'(obs_g0), 32'(1));
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    do_cycle(); check("rst_busy", 32'(obs_busy), 32'(0));
    for (int i = 0; i < 3; i++) begin
      do_cycle(); check("rst_no_rvalid", 32'(obs_rv0), 32'(0));
    end
    q0.push_back(mk(1'b0, 2, 0));
    for (int i = 0; i < 4; i++) do_cycle();
    check("rst_rd_rvalid", 32'(obs_rv0), 32'(1));
    check("rst_rd_data", 32'(obs_rdata), 32'(8'hA5));

    // Random traffic with occasional locks and resets.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 3 && $urandom_range(2) == 0)
        q0.push_back(mk(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(255))));
      if (q1.size() < 3 && $urandom_range(2) == 0)
        q1.push_back(mk(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(255))));
      bus.c1_lock = ($urandom_range(3) == 0);
      reset = ($urandom_range(99) == 0);
      do_cycle();
    end
    reset = 1'b0;
    bus.c1_lock = 1'b0;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_block != 0) && guard < 60) begin
      do_cycle();
      guard++;
    end
    check("final_drain", 32'(q0.size() + q1.size()), 32'(0));
    repeat (3) do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
